// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and helpers for the I2C target endpoint
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
  } i2c_target_state_e;

  localparam logic I2C_RW_READ = 1'b1;

  // Replace the low n bits of the base address with the strap pins.
  function automatic logic [6:0] i2c_resolve_addr(input logic [6:0] base,
                                                  input logic [2:0] pins,
                                                  input int n);
    logic [6:0] a;
    a = base;
    for (int i = 0; i < 3; i++) begin
      if (i < n) a[i] = pins[i];
    end
    return a;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchroniser with edge and START/STOP detection
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [N-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic         scl_dly_q, scl_dly_d, sda_dly_q, sda_dly_d;
  logic         scl;

  assign scl = scl_sync_q[N-1];
  assign sda = sda_sync_q[N-1];

  always_comb begin
    scl_sync_d = {scl_sync_q[N-2:0], scl_i};
    sda_sync_d = {sda_sync_q[N-2:0], sda_i};
    scl_dly_d  = scl;
    sda_dly_d  = sda;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_dly_q  <= scl_dly_d;
      sda_dly_q  <= sda_dly_d;
    end
  end

  // SCL must be high on both samples so an SDA edge coincident with SCL moving is not a condition.
  assign scl_rise  = scl & ~scl_dly_q;
  assign scl_fall  = ~scl & scl_dly_q;
  assign start_det = scl & scl_dly_q & sda_dly_q & ~sda;
  assign stop_det  = scl & scl_dly_q & ~sda_dly_q & sda;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target endpoint with strapped address and byte-wide local handshake
module i2c_target
  import i2c_pkg::*;
#(
  parameter int         ADDRESS_PINS = 2,
  parameter logic [6:0] BASE_ADDR    = 7'h50,
  parameter int         SYNC_STAGES  = 2,
  parameter int         HOLD_CYCLES  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe,
  input  logic [((ADDRESS_PINS > 0) ? ADDRESS_PINS : 1)-1:0] addr_pins,
  output logic wr_valid,
  output logic [7:0] wr_data,
  output logic wr_first,
  output logic rd_req,
  input  logic [7:0] rd_data,
  output logic busy,
  output logic nack_seen
);
  // Read data lands one clk after rd_req, so the first read bit needs a hold of at least two.
  localparam int HOLD_EFF = (HOLD_CYCLES < 2) ? 2 : HOLD_CYCLES;
  localparam int HW       = $clog2(HOLD_EFF + 1);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_target_state_e state_q, state_d;
  logic [7:0]    shift_q, shift_d, wr_data_q, wr_data_d, rx_byte;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [6:0]    my_addr;
  logic ack_q, ack_d, first_q, first_d, sda_oe_q, sda_oe_d;
  logic wr_valid_q, wr_valid_d, wr_first_q, wr_first_d, rd_req_q, rd_req_d;
  logic busy_q, busy_d, nack_q, nack_d;

  always_comb begin
    my_addr    = i2c_resolve_addr(BASE_ADDR, 3'(addr_pins), ADDRESS_PINS);
    rx_byte    = {shift_q[6:0], sda_s};
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    hold_cnt_d = hold_cnt_q;
    ack_d      = ack_q;
    first_d    = first_q;
    sda_oe_d   = sda_oe_q;
    wr_data_d  = wr_data_q;
    wr_first_d = wr_first_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    rd_req_d   = 1'b0;
    nack_d     = 1'b0;

    if (rd_req_q) shift_d = rd_data;

    // SDA only moves once the hold window after an SCL fall has elapsed.
    if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HW'(1);
      if (hold_cnt_q == HW'(1)) begin
        case (state_q)
          ADDR_ACK, WRITE_ACK: sda_oe_d = 1'b1;
          READ:                sda_oe_d = ~shift_q[7];
          default:             sda_oe_d = 1'b0;
        endcase
      end
    end

    if (start_det) begin
      state_d    = ADDR;
      bit_cnt_d  = 3'd0;
      busy_d     = 1'b0;
      ack_d      = 1'b0;
      sda_oe_d   = 1'b0;
      hold_cnt_d = '0;
    end else if (stop_det) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      sda_oe_d   = 1'b0;
      hold_cnt_d = '0;
    end else if (scl_rise) begin
      case (state_q)
        ADDR, WRITE: begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ack_d = 1'b0;
            if (state_q == ADDR) begin
              if (rx_byte[7:1] == my_addr) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              wr_valid_d = 1'b1;
              wr_data_d  = rx_byte;
              wr_first_d = first_q;
              first_d    = 1'b0;
              state_d    = WRITE_ACK;
            end
          end
        end
        ADDR_ACK, WRITE_ACK: ack_d = 1'b1;
        READ:                bit_cnt_d = bit_cnt_q + 3'd1;
        READ_ACK: begin
          if (sda_s) begin
            nack_d  = 1'b1;
            state_d = IGNORE;
          end else begin
            ack_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      hold_cnt_d = HW'(HOLD_EFF);
      case (state_q)
        ADDR_ACK: begin
          if (ack_q) begin
            bit_cnt_d = 3'd0;
            if (shift_q[0] == I2C_RW_READ) begin
              rd_req_d = 1'b1;
              state_d  = READ;
            end else begin
              first_d = 1'b1;
              state_d = WRITE;
            end
          end
        end
        WRITE_ACK: begin
          if (ack_q) begin
            bit_cnt_d = 3'd0;
            state_d   = WRITE;
          end
        end
        READ: begin
          if (bit_cnt_q == 3'd0) begin
            ack_d   = 1'b0;
            state_d = READ_ACK;
          end else begin
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
        READ_ACK: begin
          if (ack_q) begin
            rd_req_d = 1'b1;
            state_d  = READ;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      hold_cnt_q <= '0;
      ack_q      <= 1'b0;
      first_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= 8'h00;
      wr_first_q <= 1'b0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      ack_q      <= ack_d;
      first_q    <= first_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      wr_first_q <= wr_first_d;
      rd_req_q   <= rd_req_d;
      busy_q     <= busy_d;
      nack_q     <= nack_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign wr_valid  = wr_valid_q;
  assign wr_data   = wr_data_q;
  assign wr_first  = wr_first_q;
  assign rd_req    = rd_req_q;
  assign busy      = busy_q;
  assign nack_seen = nack_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed bench for the I2C target endpoint
module tb_i2c_target;
  import i2c_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic [1:0] addr_pins = 2'b01;
  logic [7:0] rd_data = 8'h00;
  logic sda_line, sda_oe, wr_valid, wr_first, rd_req, busy, nack_seen;
  logic [7:0] wr_data;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int nack_cnt = 0;
  logic oe_seen = 1'b0;
  logic [8:0] wr_log[$];

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(
    .ADDRESS_PINS (2),
    .BASE_ADDR    (7'h50),
    .SYNC_STAGES  (2),
    .HOLD_CYCLES  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .addr_pins (addr_pins),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_first  (wr_first),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .busy      (busy),
    .nack_seen (nack_seen)
  );

  always @(negedge clk) begin
    if (wr_valid) wr_log.push_back({wr_first, wr_data});
    if (rd_req) rd_cnt++;
    if (nack_seen) nack_cnt++;
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_log.delete();
    rd_cnt = 0;
    nack_cnt = 0;
    oe_seen = 1'b0;
  endtask

  task automatic qwait();
    repeat (8) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; qwait();
    scl = 1'b1;   qwait();
    sda_m = 1'b0; qwait();
    scl = 1'b0;   qwait();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; qwait();
    scl = 1'b1;   qwait();
    sda_m = 1'b1; qwait();
  endtask

  task automatic xfer_bit(input logic b, output logic s);
    sda_m = b;  qwait();
    scl = 1'b1; qwait();
    s = sda_line; qwait();
    scl = 1'b0; qwait();
  endtask

  task automatic send_byte(input logic [7:0] v, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) xfer_bit(v[i], s);
    xfer_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, s);
      v[i] = s;
    end
    xfer_bit(nack, s);
  endtask

  initial begin
    logic ack;
    logic s;
    logic [7:0] rb;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_first", wr_first, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_busy", busy, 0);
    check("rst_nack", nack_seen, 0);
    check("rst_state", dut.state_q, IDLE);

    // Write to 0x51 (strap 01 over base 0x50)
    clear_mon();
    bus_start();
    send_byte(8'hA2, ack); check("w_addr_ack", ack, 1);
    check("w_busy_after_addr", busy, 1);
    send_byte(8'h3C, ack); check("w_b1_ack", ack, 1);
    send_byte(8'h7E, ack); check("w_b2_ack", ack, 1);
    check("w_busy_before_stop", busy, 1);
    bus_stop();
    check("w_count", wr_log.size(), 2);
    check("w_b1_data_first", wr_log[0], 9'h13C);
    check("w_b2_data_first", wr_log[1], 9'h07E);
    check("w_busy_after_stop", busy, 0);
    check("w_state_idle", dut.state_q, IDLE);

    // Address mismatch
    clear_mon();
    bus_start();
    send_byte(8'hA4, ack); check("mm_addr_nack", ack, 0);
    send_byte(8'h55, ack);
    send_byte(8'hAA, ack);
    check("mm_oe_never", oe_seen, 0);
    check("mm_no_wr", wr_log.size(), 0);
    check("mm_busy", busy, 0);
    bus_stop();

    // Read two bytes, NACK the second
    clear_mon();
    rd_data = 8'h96;
    bus_start();
    send_byte(8'hA3, ack); check("r_addr_ack", ack, 1);
    rd_data = 8'h01;
    recv_byte(1'b0, rb); check("r_b1", rb, 8'h96);
    recv_byte(1'b1, rb); check("r_b2", rb, 8'h01);
    check("r_rd_req_cnt", rd_cnt, 2);
    check("r_nack_cnt", nack_cnt, 1);
    check("r_oe_released", sda_oe, 0);
    check("r_state_ignore", dut.state_q, IGNORE);
    bus_stop();

    // Repeated START: write then read
    clear_mon();
    rd_data = 8'h5A;
    bus_start();
    send_byte(8'hA2, ack); check("rs_waddr_ack", ack, 1);
    send_byte(8'h10, ack); check("rs_wdata_ack", ack, 1);
    bus_start();
    send_byte(8'hA3, ack); check("rs_raddr_ack", ack, 1);
    check("rs_busy_after_rs", busy, 1);
    recv_byte(1'b1, rb); check("rs_rbyte", rb, 8'h5A);
    check("rs_busy_before_stop", busy, 1);
    bus_stop();
    check("rs_wr_count", wr_log.size(), 1);
    check("rs_wr_data_first", wr_log[0], 9'h110);
    check("rs_rd_req_cnt", rd_cnt, 1);
    check("rs_busy_after_stop", busy, 0);

    // Reset while driving a zero read bit
    clear_mon();
    rd_data = 8'h00;
    bus_start();
    send_byte(8'hA3, ack); check("rr_addr_ack", ack, 1);
    for (int i = 0; i < 3; i++) xfer_bit(1'b1, s);
    sda_m = 1'b1; qwait();
    check("rr_oe_before", sda_oe, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rr_oe_async", sda_oe, 0);
    check("rr_state_idle", dut.state_q, IDLE);
    check("rr_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    scl = 1'b1;
    qwait(); qwait();
    clear_mon();
    bus_start();
    send_byte(8'hA2, ack); check("rr_post_addr_ack", ack, 1);
    send_byte(8'h99, ack); check("rr_post_data_ack", ack, 1);
    bus_stop();
    check("rr_post_wr_count", wr_log.size(), 1);
    check("rr_post_wr", wr_log[0], 9'h199);

    // STOP after four bits of a data byte
    clear_mon();
    bus_start();
    send_byte(8'hA2, ack); check("ab_addr_ack", ack, 1);
    xfer_bit(1'b1, s); xfer_bit(1'b0, s); xfer_bit(1'b1, s); xfer_bit(1'b1, s);
    bus_stop();
    check("ab_no_wr", wr_log.size(), 0);
    check("ab_state_idle", dut.state_q, IDLE);
    check("ab_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) endpoint: the bus-side counterpart of a controller driving SCL on the shared two-wire I2C interface.
- Oversamples SCL/SDA on the system clock and decodes START/STOP.
- Matches a 7-bit address whose low bits come from strap pins.
- Presents write bytes and read-byte requests on a simple byte-wide local handshake.
- No clock stretching; supports repeated START.

Parameters:
- ADDRESS_PINS, 2, number of strapped low address bits (0..3). When 0, the addr_pins port is a 1-bit input that is ignored.
- BASE_ADDR, 7'h50, 7-bit target address. Bits [ADDRESS_PINS-1:0] are replaced by addr_pins.
- SYNC_STAGES, 2, flip-flop synchroniser depth on scl_i/sda_i (minimum 2).
- HOLD_CYCLES, 4, clk cycles after a detected SCL falling edge before sda_oe may change.

Ports:
- clk  input  1  system clock; must be at least 16x the SCL rate.
- rst  input  1  asynchronous, active-high reset.
- scl_i  input  1  SCL pad input.
- sda_i  input  1  SDA pad input.
- sda_oe  output  1  1 = pull SDA low (open-drain). The target never drives SDA high.
- addr_pins  input  max(ADDRESS_PINS,1)  strap pins; sampled on each address phase.
- wr_valid  output  1  one-cycle pulse: wr_data holds a received write byte.
- wr_data  output  8  received byte; held until the next wr_valid.
- wr_first  output  1  qualifies wr_valid: first data byte after the address.
- rd_req  output  1  one-cycle pulse: supply the next read byte.
- rd_data  input  8  read byte; sampled exactly 1 clk after rd_req.
- busy  output  1  high from an address match until STOP or a non-matching START.
- nack_seen  output  1  one-cycle pulse: controller NACKed a read byte.

Behaviour:
- Reset values: sda_oe=0, wr_valid=0, wr_data=0, wr_first=0, rd_req=0, busy=0, nack_seen=0. FSM=IDLE, synchronisers preset to 1. Reset mid-transfer releases SDA immediately (asynchronous).
- Edge detection uses the synchronised SCL/SDA and their 1-cycle-delayed copies.
  - START = SDA 1->0 while SCL=1.
  - STOP = SDA 0->1 while SCL=1.
  - Data is sampled on SCL rising edge.
  - sda_oe updates HOLD_CYCLES clk after SCL falling edge.
- START in any state goes to ADDR with bit counter=0 and clears busy. STOP in any state goes to IDLE, clears busy, releases sda_oe. START takes effect even mid-byte.
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first (7 address bits + R/W).
    - On match -> ADDR_ACK, busy=1.
    - On mismatch -> IGNORE.
  - ADDR_ACK: sda_oe=1 for one SCL period.
    - If R/W=0 -> WRITE, and set wr_first for the next byte.
    - If R/W=1 -> pulse rd_req on the SCL falling edge that ends ACK, load the shift register from rd_data, then -> READ.
  - WRITE: shift 8 bits. On the 8th rising edge, pulse wr_valid with wr_data/wr_first (wr_first then clears) -> WRITE_ACK.
  - WRITE_ACK: sda_oe=1 for one SCL period, then -> WRITE. A write is always ACKed.
  - READ: sda_oe = ~shift[7] for each bit, shifting on each falling edge. After 8 bits, release SDA -> READ_ACK.
  - READ_ACK: sample SDA on the rising edge.
    - 0 (ACK) -> pulse rd_req, reload, -> READ.
    - 1 (NACK) -> pulse nack_seen -> IGNORE.
  - IGNORE: sda_oe=0; wait for START/STOP.
- Bit counter is 3 bits and wraps 7->0 at byte end.
- Glitch rule: SDA changes while SCL=1 outside START/STOP detection are never sampled as data.
- The general call address (0x00) is not matched unless BASE_ADDR/addr_pins resolve to 0.

Decomposition:
- Package i2c_pkg holds:
  - typedef enum i2c_target_state_e {IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE}.
  - localparam I2C_RW_READ=1'b1.
  - Helper function i2c_resolve_addr(base, pins, n).
- Sub-module i2c_bus_sync: per-line synchroniser plus edge/START/STOP detection. It is reused by a future controller block.

Test Plan:
- Write, addr_pins=2'b01, BASE 0x50: START, 0xA2 (addr 0x51, W), 0x3C, 0x7E, STOP.
  - Required: ACK on all 3 bytes.
  - wr_valid twice: 0x3C with wr_first=1, then 0x7E with wr_first=0.
  - busy high from the address ACK until STOP.
- Address mismatch: START, 0xA4 (addr 0x52).
  - Required: sda_oe stays 0 through the ACK slot and the following 2 bytes; no wr_valid; busy=0.
- Read with final NACK: START, 0xA3; rd_data returns 0x96 then 0x01; controller ACKs byte 1, NACKs byte 2.
  - Required: SDA bits 10010110, then 00000001; rd_req pulses twice; nack_seen pulses once; sda_oe=0 afterward.
- Repeated START: write 0xA2, 0x10, then START, 0xA3, read 1 byte, NACK, STOP.
  - Required: wr_valid 0x10, one rd_req, busy cleared at STOP.
- Reset mid-read: assert rst while sda_oe=1 during bit 3.
  - Required: sda_oe=0 in the same cycle; FSM=IDLE; the next START/address transaction completes normally.
- Abort: STOP after 4 bits of a write data byte.
  - Required: no wr_valid; IDLE; busy=0.
